// File: rtl/wr_valid_gen.sv
// FIFO write-side burst generator: fills FIFO_DEPTH words, waits for empty, repeats.
// Optional WR_VALID_GEN_BURST_CNT_EN builds a saturating completed-burst counter.
module wr_valid_gen #(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned COUNTER_WIDTH = 3,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  full,
  input  logic                  empty,
  output logic                  wr_valid,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  burst_done,
  output logic [15:0]           burst_count
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN_WAIT} state_t;

  localparam logic [COUNTER_WIDTH:0] DEPTH = FIFO_DEPTH[COUNTER_WIDTH:0];

  state_t                  state, state_next;
  logic [COUNTER_WIDTH:0]  counter, counter_next;
  logic [DATA_WIDTH-1:0]   data_next;
  logic                    done_next;

  always_comb begin
    wr_valid = (state == FILL) && !full && (counter < DEPTH) && !reset;
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    data_next    = wr_data;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next   = FILL;
          counter_next = '0;
        end
      end
      FILL: begin
        // premature full ends the burst even though counter is short
        if (full) begin
          state_next = DRAIN_WAIT;
          done_next  = 1'b1;
        end else if (wr_valid) begin
          counter_next = counter + 1'b1;
          data_next    = wr_data + 1'b1;
          if (counter == DEPTH - 1'b1) begin
            state_next = DRAIN_WAIT;
            done_next  = 1'b1;
          end
        end
      end
      DRAIN_WAIT: begin
        if (empty) begin
          state_next   = enable ? FILL : IDLE;
          counter_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      wr_data    <= '0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_next;
      counter    <= counter_next;
      wr_data    <= data_next;
      burst_done <= done_next;
    end
  end

`ifdef WR_VALID_GEN_BURST_CNT_EN
  always_ff @(posedge wr_clk) begin
    if (reset) begin
      burst_count <= '0;
    end else if (burst_done && (burst_count != '1)) begin
      burst_count <= burst_count + 16'd1;
    end
  end
`else
  assign burst_count = '0;
`endif

endmodule

// File: tb/tb_wr_valid_gen.sv
// Self-checking bench for wr_valid_gen: vector table, directed corner sequences,
// and randomized stimulus against a burst-level reference model.
module tb_wr_valid_gen;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 3;
  localparam int unsigned DW    = 8;

  logic          wr_clk = 1'b0;
  logic          reset, enable, full, empty;
  logic          wr_valid, burst_done;
  logic [DW-1:0] wr_data;
  logic [15:0]   burst_count;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: burst bookkeeping, not a state encoding
  bit          m_active, m_drain, m_done;
  int unsigned m_written, m_data, m_bursts;
  logic        cur_r, cur_en, cur_f, cur_e;
  int unsigned writes;

  wr_valid_gen #(.FIFO_DEPTH(DEPTH), .COUNTER_WIDTH(CW), .DATA_WIDTH(DW)) dut (
    .wr_clk(wr_clk), .reset(reset), .enable(enable), .full(full), .empty(empty),
    .wr_valid(wr_valid), .wr_data(wr_data), .burst_done(burst_done),
    .burst_count(burst_count)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct packed {
    logic r, en, f, e, v;
    logic [7:0] d;
    logic done;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned exp_count();
`ifdef WR_VALID_GEN_BURST_CNT_EN
    return m_bursts;
`else
    return 0;
`endif
  endfunction

  task automatic apply(input logic r, input logic en, input logic f, input logic e);
    reset = r; enable = en; full = f; empty = e;
    cur_r = r; cur_en = en; cur_f = f; cur_e = e;
    #1;
    chk("wr_valid", {31'd0, wr_valid}, {31'd0, m_active && !f && !r});
    chk("wr_data", {24'd0, wr_data}, m_data);
    chk("burst_done", {31'd0, burst_done}, {31'd0, m_done});
    chk("burst_count", {16'd0, burst_count}, exp_count());
    if (wr_valid === 1'b1) writes++;
  endtask

  task automatic model_update();
    bit done_new;
    done_new = 1'b0;
    if (cur_r) begin
      m_active = 0; m_drain = 0; m_done = 0;
      m_written = 0; m_data = 0; m_bursts = 0;
    end else begin
      if (m_active) begin
        if (cur_f) begin
          m_active = 0; m_drain = 1; done_new = 1;
        end else begin
          m_data = (m_data + 1) % (1 << DW);
          m_written++;
          if (m_written == DEPTH) begin
            m_active = 0; m_drain = 1; done_new = 1;
          end
        end
      end else if (m_drain) begin
        if (cur_e) begin
          m_drain = 0;
          if (cur_en) begin m_active = 1; m_written = 0; end
        end
      end else if (cur_en) begin
        m_active = 1; m_written = 0;
      end
      if (m_done && m_bursts < 65535) m_bursts++;
      m_done = done_new;
    end
  endtask

  task automatic advance();
    @(posedge wr_clk);
    model_update();
    @(negedge wr_clk);
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    advance();
  endtask

  initial begin
    int cyc;

    // first reset: outputs are unknown until this edge
    reset = 1'b1; enable = 1'b0; full = 1'b0; empty = 1'b0;
    cur_r = 1'b1; cur_en = 1'b0; cur_f = 1'b0; cur_e = 1'b0;
    writes = 0;
    @(negedge wr_clk);
    advance();

    // basic burst: reset gate, one-cycle latency, data 0..7, single done pulse
    tbl[0] = '{r:1, en:1, f:0, e:1, v:0, d:8'd0, done:0};
    tbl[1] = '{r:0, en:1, f:0, e:1, v:0, d:8'd0, done:0};
    for (int unsigned i = 2; i < 10; i++)
      tbl[i] = '{r:0, en:1, f:0, e:1, v:1, d:8'(i - 2), done:0};
    tbl[10] = '{r:0, en:0, f:0, e:0, v:0, d:8'd8, done:1};
    tbl[11] = '{r:0, en:0, f:0, e:1, v:0, d:8'd8, done:0};
    tbl[12] = '{r:0, en:0, f:0, e:1, v:0, d:8'd8, done:0};
    for (int unsigned i = 0; i < 13; i++) begin
      apply(tbl[i].r, tbl[i].en, tbl[i].f, tbl[i].e);
      chk("tbl_valid", {31'd0, wr_valid}, {31'd0, tbl[i].v});
      chk("tbl_data", {24'd0, wr_data}, {24'd0, tbl[i].d});
      chk("tbl_done", {31'd0, burst_done}, {31'd0, tbl[i].done});
      advance();
    end

    // burst 8..15, then 5 cycles with empty low, then next burst from 16
    apply(0, 1, 0, 0); advance();
    for (int unsigned i = 0; i < DEPTH; i++) begin
      apply(0, 1, 0, 0);
      chk("burst2_data", {24'd0, wr_data}, 8 + i);
      advance();
    end
    for (int unsigned i = 0; i < 5; i++) begin
      apply(0, 1, 0, 0);
      chk("drain_wait_valid", {31'd0, wr_valid}, 32'd0);
      advance();
    end
    apply(0, 1, 0, 1); advance();
    apply(0, 1, 0, 1);
    chk("burst3_first", {24'd0, wr_data}, 32'd16);
    advance();

    // premature full after 3 writes
    do_reset();
    apply(0, 1, 0, 1); advance();
    for (int unsigned i = 0; i < 3; i++) begin apply(0, 1, 0, 0); advance(); end
    apply(0, 1, 1, 0);
    chk("full_drops_valid", {31'd0, wr_valid}, 32'd0);
    advance();
    apply(0, 1, 0, 1);
    chk("full_done", {31'd0, burst_done}, 32'd1);
    advance();
    apply(0, 1, 0, 1);
    chk("resume_data", {24'd0, wr_data}, 32'd3);
    chk("resume_valid", {31'd0, wr_valid}, 32'd1);
    advance();

    // reset after the 4th write of a burst
    do_reset();
    apply(0, 1, 0, 0); advance();
    for (int unsigned i = 0; i < 4; i++) begin apply(0, 1, 0, 0); advance(); end
    apply(1, 1, 0, 0);
    chk("reset_gate_valid", {31'd0, wr_valid}, 32'd0);
    advance();
    apply(0, 0, 0, 1);
    chk("reset_data", {24'd0, wr_data}, 32'd0);
    chk("reset_idle_valid", {31'd0, wr_valid}, 32'd0);
    advance();
    apply(0, 1, 0, 1); advance();
    apply(0, 1, 0, 1);
    chk("restart_data", {24'd0, wr_data}, 32'd0);
    chk("restart_valid", {31'd0, wr_valid}, 32'd1);
    advance();

    // enable dropped after 2 writes: burst still completes, then idle
    do_reset();
    apply(0, 1, 0, 0); advance();
    writes = 0;
    for (int unsigned i = 0; i < 2; i++) begin apply(0, 1, 0, 0); advance(); end
    for (int unsigned i = 0; i < 10; i++) begin apply(0, 0, 0, 0); advance(); end
    chk("drop_enable_writes", writes, DEPTH);
    apply(0, 0, 0, 1); advance();
    for (int unsigned i = 0; i < 3; i++) begin
      apply(0, 0, 0, 1);
      chk("idle_after_drop", {31'd0, wr_valid}, 32'd0);
      advance();
    end

    // 32 back-to-back bursts: 256 words, data wraps to 0 without a gap
    do_reset();
    writes = 0;
    cyc = 0;
    while (writes < 32 * DEPTH && cyc < 400) begin
      apply(0, 1, 0, 1);
      advance();
      cyc++;
    end
    chk("burst32_bound", writes, 32 * DEPTH);
    for (int unsigned i = 0; i < 4; i++) begin apply(0, 0, 0, 1); advance(); end
    apply(0, 0, 0, 1);
    chk("wrap_data", {24'd0, wr_data}, 32'd0);
`ifdef WR_VALID_GEN_BURST_CNT_EN
    chk("burst_count_32", {16'd0, burst_count}, 32'd32);
`else
    chk("burst_count_off", {16'd0, burst_count}, 32'd0);
`endif
    advance();

    // randomized traffic, including illegal full+empty and sporadic resets
    for (int unsigned i = 0; i < 3000; i++) begin
      apply(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 80),
            1'($urandom_range(0, 99) < 10), 1'($urandom_range(0, 99) < 35));
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
